// File: rtl/call_request_encoder.sv
// Push-button front end: sync, debounce, sticky call latch, one request at a time to the scheduler.
// Latency: press pulse -> pending next cycle -> req_valid one cycle later; offer held until req_ready.
// Optional CALL_CANCEL_EN: re-press of a pending (not currently offered) call cancels it.
module call_request_encoder #(
  parameter int NUM_BTNS        = 9,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] push_btns,
  output logic                req_valid,
  output logic [3:0]          req_floor,
  input  logic                req_ready,
  output logic [NUM_BTNS-1:0] pending
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic {IDLE, OFFER} state_t;

  logic [CW-1:0]       cnt_q;
  logic                tick;
  logic [NUM_BTNS-1:0] sync1_q, sync2_q, samp_q, deb_q, deb_d_q;
  logic [NUM_BTNS-1:0] stable, press;

  state_t              state_q, state_d;
  logic [3:0]          sel_q, sel_d;
  logic [3:0]          floor_q, floor_d;
  logic [NUM_BTNS-1:0] pending_q, pending_d;
  logic [NUM_BTNS-1:0] sel_oh, clr, cancel;
  logic [3:0]          low_idx;

  assign tick   = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign stable = ~(sync2_q ^ samp_q);
  assign press  = deb_q & ~deb_d_q;

  // Input conditioning: a level must match across two ticks before deb follows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
      deb_q   <= '0;
      deb_d_q <= '0;
    end else begin
      cnt_q   <= tick ? '0 : cnt_q + CW'(1);
      sync1_q <= push_btns;
      sync2_q <= sync1_q;
      deb_d_q <= deb_q;
      if (tick) begin
        samp_q <= sync2_q;
        deb_q  <= (deb_q & ~stable) | (sync2_q & stable);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      floor_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    floor_d = floor_q;
    low_idx = '0;
    sel_oh  = '0;
    clr     = '0;
    cancel  = '0;

    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = 4'(i);
    end
    for (int i = 0; i < NUM_BTNS; i++) begin
      sel_oh[i] = (sel_q == 4'(i));
    end

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          sel_d   = low_idx;
          floor_d = low_idx + 4'd1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (req_ready) begin
          clr     = sel_oh;
          floor_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef CALL_CANCEL_EN
    // The call on offer is locked; cancelling it would retract a visible request.
    cancel = press & pending_q & ~((state_q == OFFER) ? sel_oh : '0);
`else
    cancel = '0;
`endif

    // A press coinciding with acceptance of the same button re-arms it.
    pending_d = (pending_q & ~clr & ~cancel) | (press & ~cancel);
  end

  assign req_valid = (state_q == OFFER);
  assign req_floor = floor_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_call_request_encoder.sv
// Scoreboard bench for call_request_encoder with a short debounce period.
module tb_call_request_encoder;

  localparam int NB = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] push_btns = '0;
  logic          req_ready = 1'b0;
  logic          req_valid;
  logic [3:0]    req_floor;
  logic [NB-1:0] pending;

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_q[$];
  bit   mon_en = 1'b0;
  int   valid_cycles = 0;
  bit   stall_q = 1'b0;
  logic [3:0] held_floor = '0;

  always #5 clk = ~clk;

  call_request_encoder #(.NUM_BTNS(NB), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .push_btns (push_btns),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .req_ready (req_ready),
    .pending   (pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !req_valid; i++) cyc(1);
  endtask

  task automatic press_release(input int idx);
    push_btns[idx] = 1'b1;
    cyc(12);
    push_btns[idx] = 1'b0;
    cyc(12);
  endtask

  // Output monitor: handshake scoreboard, offer stability, idle floor.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!req_valid) check("floor_idle", req_floor, 0);
      if (stall_q) begin
        check("hold_valid", req_valid, 1);
        check("hold_floor", req_floor, held_floor);
      end
      if (req_valid) valid_cycles++;
      if (!rst && req_valid && req_ready) begin
        if (exp_q.size() == 0) check("unexpected_req", req_floor, 0);
        else check("req_floor", req_floor, exp_q.pop_front());
      end
      stall_q    = req_valid && !req_ready && !rst;
      held_floor = req_floor;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  v0;
    bit  saw;

    // Reset with every button held.
    rst = 1'b1;
    push_btns = '1;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_valid", req_valid, 0);
      check("rst_floor", req_floor, 0);
      check("rst_pending", pending, 0);
      cyc(1);
    end
    rst = 1'b0;
    push_btns = '0;
    mon_en = 1'b1;
    cyc(15);
    check("post_rst_pending", pending, 0);

    // Single press with ready high.
    req_ready = 1'b1;
    exp_q.push_back(3);
    v0 = valid_cycles;
    saw = 1'b0;
    push_btns[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (pending == 9'h004) saw = 1'b1;
    end
    push_btns = '0;
    cyc(15);
    check("single_pending_seen", saw, 1);
    check("single_valid_cycles", valid_cycles - v0, 1);
    check("single_pending_clr", pending, 0);

    // Short glitch must not register.
    v0 = valid_cycles;
    saw = 1'b0;
    push_btns[5] = 1'b1;
    cyc(3);
    push_btns = '0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (pending != 0) saw = 1'b1;
    end
    check("glitch_pending", saw, 0);
    check("glitch_valid_cycles", valid_cycles - v0, 0);

    // Two buttons together under backpressure: lowest first.
    req_ready = 1'b0;
    exp_q.push_back(2);
    exp_q.push_back(8);
    push_btns = 9'h082;
    wait_valid(30);
    check("prio_valid", req_valid, 1);
    check("prio_pending", pending, 9'h082);
    check("prio_floor", req_floor, 2);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("bp_valid", req_valid, 1);
      check("bp_floor", req_floor, 2);
    end
    push_btns = '0;
    cyc(15);
    req_ready = 1'b1;
    @(negedge clk);
    check("xfer1_valid", req_valid, 1);
    check("xfer1_floor", req_floor, 2);
    @(negedge clk);
    check("bubble_valid", req_valid, 0);
    @(negedge clk);
    check("xfer2_valid", req_valid, 1);
    check("xfer2_floor", req_floor, 8);
    cyc(5);
    check("prio_pending_clr", pending, 0);

    // Reset in the middle of an offer drops it.
    req_ready = 1'b0;
    push_btns[3] = 1'b1;
    wait_valid(30);
    check("mid_valid", req_valid, 1);
    check("mid_floor", req_floor, 4);
    push_btns = '0;
    rst = 1'b1;
    cyc(1);
    check("mid_rst_valid", req_valid, 0);
    check("mid_rst_floor", req_floor, 0);
    check("mid_rst_pending", pending, 0);
    cyc(1);
    rst = 1'b0;
    cyc(15);

    // Re-presses: offered call is locked, others toggle only with cancel enabled.
    req_ready = 1'b0;
    exp_q.push_back(5);
    press_release(4);
    press_release(4);
    press_release(6);
    press_release(6);
    check("cancel_valid", req_valid, 1);
    check("cancel_floor", req_floor, 5);
`ifdef CALL_CANCEL_EN
    check("cancel_pending", pending, 9'h010);
`else
    exp_q.push_back(7);
    check("cancel_pending", pending, 9'h050);
`endif
    req_ready = 1'b1;
    cyc(10);
    check("cancel_pending_clr", pending, 0);
    req_ready = 1'b0;
    cyc(3);

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/call_request_encoder.md
# call_request_encoder

Input-side front end for the elevator controller: conditions the raw push-button bank, latches each press as a sticky call request, and hands requests one at a time to the scheduler over a valid/ready handshake. It sits between the board push buttons and the scheduling/motor logic, and is the producer for the scheduler's request input.

## Interface

- `NUM_BTNS`, 9: number of push buttons (floor calls); max 15.
- `DEBOUNCE_CYCLES`, 240000: clk cycles between debounce sample ticks; same period as one motor half-step.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `push_btns`  in  NUM_BTNS  raw asynchronous buttons, 1 = pressed.
- `req_valid`  out  1  a request is being offered.
- `req_floor`  out  4  offered floor, 1..NUM_BTNS (button index + 1); 0 when `req_valid`=0.
- `req_ready`  in  1  scheduler accepts the offer this cycle.
- `pending`  out  NUM_BTNS  latched, not-yet-accepted calls (drives the dot-matrix call indicators).

## Operation

- Synchronizer: two flops per button; button logic sees only the synchronized value.
- Tick counter: counts 0..DEBOUNCE_CYCLES-1, wraps; `tick`=1 in the cycle where count = DEBOUNCE_CYCLES-1.
- Debounce: on `tick`, `samp[i]` <= sync[i]; `deb[i]` <= sync[i] only if sync[i] == old `samp[i]`. A level must be stable across two consecutive ticks to change `deb`.
- Press pulse: `press[i]` = `deb[i]` & ~`deb_d[i]`; one cycle wide.
- Pending set: `press[i]` sets `pending[i]`. Re-press of an already-pending button: no effect (see Configuration).
- FSM, two states:
  - IDLE: `req_valid`=0. If `pending` != 0 -> latch `sel` = lowest set index, `req_floor` <= `sel`+1, go OFFER.
  - OFFER: `req_valid`=1; `req_floor` held stable. If `req_ready` -> clear `pending[sel]`, `req_floor` <= 0, go IDLE.
- Priority: lowest floor first; no reordering while in OFFER.
- Simultaneous accept and new press of the same button: set wins; `pending[sel]` stays 1 and is re-offered after the IDLE cycle.
- Simultaneous presses on several buttons: all set in the same cycle.

## Timing

- Reset values: `req_valid`=0, `req_floor`=0, `pending`=0, FSM=IDLE, tick counter=0, sync/`samp`/`deb`/`deb_d`=0.
- Reset mid-offer: next cycle all outputs are at reset values; the offered request is lost.
- Press latency: `press` at cycle N -> `pending[i]`=1 at N+1 -> `req_valid`=1 at N+2 if idle.
- Raw button to `deb`: 2 sync cycles plus 1 to 2 tick periods.
- Handshake: transfer occurs on the rising edge where `req_valid`&`req_ready`. `req_valid`=0 the following cycle, so there is one bubble cycle between consecutive requests (max one request per 2 cycles).
- `req_ready` while `req_valid`=0: ignored.
- `req_valid` never drops without a transfer, except on reset.

## Configuration

- `CALL_CANCEL_EN` defined: a `press` on a button whose `pending` bit is already 1 clears the bit (toggle cancel). Exception: the bit currently offered in OFFER is locked. The cancel is ignored and the offer completes normally.
- `CALL_CANCEL_EN` undefined: a re-press of a pending button has no effect. `pending` bits clear only by acceptance or reset.

## Test plan

Sim parameters: `DEBOUNCE_CYCLES`=4, `NUM_BTNS`=9.

- Reset: `rst`=1 for 3 cycles with all buttons held high -> `req_valid`=0, `req_floor`=0, `pending`=0 throughout reset.
- Single press: hold `push_btns[2]` for 20 cycles, `req_ready`=1 -> `pending`=9'h004, then `req_valid`=1 for exactly one cycle with `req_floor`=3, then `pending`=0.
- Glitch reject: pulse `push_btns[5]` high for 3 cycles -> `pending` stays 0, `req_valid` never asserts.
- Priority and backpressure: press buttons 7 and 1 together with `req_ready`=0 for 10 cycles -> `req_floor`=2 held stable with `req_valid`=1. Raise `req_ready` -> floor 2 accepted, one bubble cycle, then `req_floor`=8 offered.
- Reset mid-offer: assert `rst` while `req_valid`=1 with `req_floor`=4 -> next cycle `req_valid`=0, `req_floor`=0, `pending`=0.
- Cancel: with `CALL_CANCEL_EN`, `req_ready`=0, press btn 4, release, press btn 4 again, press btn 6 twice -> btn 6 cleared; btn 4 still offered as `req_floor`=5. Without the macro, both bits stay set.
